// File: rtl/mips_ctl_pkg.sv
// Shared decode constants, forward encodings and controller state
// encodings for the MIPS decode-stage hazard controller.
package mips_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_RESET = 2'b10
    } ctl_state_t;

    // $0 is hardwired, so it can never be the subject of a hazard
    function automatic logic src_hit(input logic       used,
                                     input logic [4:0] src,
                                     input logic [4:0] dest);
        return used && (src != 5'd0) && (src == dest);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       exmem_rw,
                                           input logic       exmem_mr,
                                           input logic [4:0] exmem_dest,
                                           input logic       memwb_rw,
                                           input logic [4:0] memwb_dest);
        if (exmem_rw && !exmem_mr && src_hit(1'b1, src, exmem_dest))
            return FWD_EXMEM;
        else if (memwb_rw && src_hit(1'b1, src, memwb_dest))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_need_decode.sv
// Combinational decode of the ID instruction: stall need, branch flag
// and branch-compare forwarding selects.
module hazard_need_decode
    import mips_ctl_pkg::*;
(
    input  logic [31:0] idInstr,
    input  logic        idexRegWrite,
    input  logic        idexMemRead,
    input  logic [4:0]  idexDestReg,
    input  logic        exmemRegWrite,
    input  logic        exmemMemRead,
    input  logic [4:0]  exmemDestReg,
    input  logic        memwbRegWrite,
    input  logic [4:0]  memwbDestReg,
    output logic [1:0]  need,
    output logic        isBranch,
    output logic [1:0]  branchFwdA,
    output logic [1:0]  branchFwdB
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       idex_hit;
    logic       exmem_hit;
    logic       unused_imm;

    assign op = idInstr[31:26];
    assign rs = idInstr[25:21];
    assign rt = idInstr[20:16];
    assign unused_imm = ^idInstr[15:0];

    always_comb begin
        isBranch  = (op == OP_BEQ) || (op == OP_BNE);
        uses_rs   = !((op == OP_J) || (op == OP_JAL));
        uses_rt   = (op == OP_RTYPE) || isBranch || (op == OP_SW);
        idex_hit  = src_hit(uses_rs, rs, idexDestReg)
                 || src_hit(uses_rt, rt, idexDestReg);
        exmem_hit = src_hit(uses_rs, rs, exmemDestReg)
                 || src_hit(uses_rt, rt, exmemDestReg);

        need = 2'd0;
        if (isBranch) begin
            if (idexMemRead && idex_hit)
                need = 2'd2;
            else if ((idexRegWrite && idex_hit) || (exmemMemRead && exmem_hit))
                need = 2'd1;
        end else if (idexMemRead && idex_hit) begin
            need = 2'd1;
        end

        branchFwdA = FWD_RF;
        branchFwdB = FWD_RF;
        if (isBranch) begin
            branchFwdA = fwd_sel(rs, exmemRegWrite, exmemMemRead, exmemDestReg,
                                 memwbRegWrite, memwbDestReg);
            branchFwdB = fwd_sel(rt, exmemRegWrite, exmemMemRead, exmemDestReg,
                                 memwbRegWrite, memwbDestReg);
        end
    end

endmodule

// File: rtl/branch_hazard_controller.sv
// Decode-stage stall/flush sequencer for ID-resolved branches, with a
// saturating stall-cycle counter.
module branch_hazard_controller
    import mips_ctl_pkg::*;
#(
    parameter int COUNT_W   = 32,
    parameter int MAX_STALL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        idInstr,
    input  logic               idexRegWrite,
    input  logic               idexMemRead,
    input  logic [4:0]         idexDestReg,
    input  logic               exmemRegWrite,
    input  logic               exmemMemRead,
    input  logic [4:0]         exmemDestReg,
    input  logic               memwbRegWrite,
    input  logic [4:0]         memwbDestReg,
    input  logic               branchTaken,
    output logic               pcWrite,
    output logic               ifidWrite,
    output logic               idexBubble,
    output logic               ifidFlush,
    output logic               branchResolve,
    output logic [1:0]         branchFwdA,
    output logic [1:0]         branchFwdB,
    output logic [COUNT_W-1:0] stallCount,
    output logic [1:0]         ctlState
);

    localparam int REM_W = $clog2(MAX_STALL + 1);

    ctl_state_t       state;
    logic [REM_W-1:0] remaining;
    logic [1:0]       need;
    logic             is_branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    hazard_need_decode u_decode (
        .idInstr       (idInstr),
        .idexRegWrite  (idexRegWrite),
        .idexMemRead   (idexMemRead),
        .idexDestReg   (idexDestReg),
        .exmemRegWrite (exmemRegWrite),
        .exmemMemRead  (exmemMemRead),
        .exmemDestReg  (exmemDestReg),
        .memwbRegWrite (memwbRegWrite),
        .memwbDestReg  (memwbDestReg),
        .need          (need),
        .isBranch      (is_branch),
        .branchFwdA    (fwd_a),
        .branchFwdB    (fwd_b)
    );

    // Stall outputs are the default; only a hazard-free RUN cycle advances
    always_comb begin
        pcWrite       = 1'b0;
        ifidWrite     = 1'b0;
        idexBubble    = 1'b1;
        ifidFlush     = 1'b0;
        branchResolve = 1'b0;
        branchFwdA    = FWD_RF;
        branchFwdB    = FWD_RF;
        if (state == ST_RUN && need == 2'd0) begin
            pcWrite       = 1'b1;
            ifidWrite     = 1'b1;
            idexBubble    = 1'b0;
            branchResolve = is_branch;
            ifidFlush     = is_branch && branchTaken;
            branchFwdA    = fwd_a;
            branchFwdB    = fwd_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RESET;
            remaining <= '0;
        end else begin
            unique case (state)
                ST_RESET: begin
                    state     <= ST_RUN;
                    remaining <= '0;
                end
                ST_RUN: begin
                    if (need > 2'd1) begin
                        state     <= ST_HOLD;
                        remaining <= REM_W'(need - 2'd1);
                    end
                end
                ST_HOLD: begin
                    remaining <= remaining - 1'b1;
                    if (remaining <= REM_W'(1))
                        state <= ST_RUN;
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stallCount <= '0;
        else if (!pcWrite && stallCount != '1)
            stallCount <= stallCount + 1'b1;
    end

    assign ctlState = state;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed, table-driven bench for branch_hazard_controller plus
// hand-written HOLD and reset-during-HOLD sequences.
module tb_branch_hazard_controller;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   idInstr;
    logic          idexRegWrite, idexMemRead;
    logic [4:0]    idexDestReg;
    logic          exmemRegWrite, exmemMemRead;
    logic [4:0]    exmemDestReg;
    logic          memwbRegWrite;
    logic [4:0]    memwbDestReg;
    logic          branchTaken;
    logic          pcWrite, ifidWrite, idexBubble, ifidFlush, branchResolve;
    logic [1:0]    branchFwdA, branchFwdB;
    logic [CW-1:0] stallCount;
    logic [1:0]    ctlState;

    branch_hazard_controller #(.COUNT_W(CW), .MAX_STALL(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .idInstr       (idInstr),
        .idexRegWrite  (idexRegWrite),
        .idexMemRead   (idexMemRead),
        .idexDestReg   (idexDestReg),
        .exmemRegWrite (exmemRegWrite),
        .exmemMemRead  (exmemMemRead),
        .exmemDestReg  (exmemDestReg),
        .memwbRegWrite (memwbRegWrite),
        .memwbDestReg  (memwbDestReg),
        .branchTaken   (branchTaken),
        .pcWrite       (pcWrite),
        .ifidWrite     (ifidWrite),
        .idexBubble    (idexBubble),
        .ifidFlush     (ifidFlush),
        .branchResolve (branchResolve),
        .branchFwdA    (branchFwdA),
        .branchFwdB    (branchFwdB),
        .stallCount    (stallCount),
        .ctlState      (ctlState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        x_rw, x_mr;
        logic [4:0]  x_d;
        logic        m_rw, m_mr;
        logic [4:0]  m_d;
        logic        w_rw;
        logic [4:0]  w_d;
        logic        tk;
        logic        pcw, fl, res;
        logic [1:0]  fa, fb;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    int   total = 0;
    int   passed = 0;
    int   exp_cnt = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input logic [4:0] rs, rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        idInstr       = v.instr;
        idexRegWrite  = v.x_rw;
        idexMemRead   = v.x_mr;
        idexDestReg   = v.x_d;
        exmemRegWrite = v.m_rw;
        exmemMemRead  = v.m_mr;
        exmemDestReg  = v.m_d;
        memwbRegWrite = v.w_rw;
        memwbDestReg  = v.w_d;
        branchTaken   = v.tk;
    endtask

    task automatic bump();
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    endtask

    // Entered at posedge+1; returns at the next posedge+1
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        #2;
        chk({tag, " pcWrite"},   32'(pcWrite),       32'(v.pcw));
        chk({tag, " ifidWrite"}, 32'(ifidWrite),     32'(v.pcw));
        chk({tag, " bubble"},    32'(idexBubble),    32'(!v.pcw));
        chk({tag, " flush"},     32'(ifidFlush),     32'(v.fl));
        chk({tag, " resolve"},   32'(branchResolve), 32'(v.res));
        chk({tag, " fwdA"},      32'(branchFwdA),    32'(v.fa));
        chk({tag, " fwdB"},      32'(branchFwdB),    32'(v.fb));
        chk({tag, " state"},     32'(ctlState),      32'd0);
        chk({tag, " stallCount"}, 32'(stallCount),   32'(exp_cnt));
        @(posedge clk);
        #1;
        if (!v.pcw) bump();
    endtask

    vec_t nop, v;

    initial begin
        nop = '{32'd0, 0,0,5'd0, 0,0,5'd0, 0,5'd0, 0, 1,0,0, 2'd0,2'd0};
        //             instr              xrw xmr xd  mrw mmr md  wrw wd tk pcw fl res fa fb
        vecs[0]  = '{rtype(8,2,9),          1,1,5'd8, 0,0,5'd0, 0,5'd0, 0, 0,0,0, 2'd0,2'd0};
        vecs[1]  = '{rtype(8,2,9),          0,0,5'd0, 1,1,5'd8, 0,5'd0, 0, 1,0,0, 2'd0,2'd0};
        vecs[2]  = '{itype(6'b000101,7,3),  0,0,5'd0, 1,0,5'd3, 0,5'd0, 1, 1,1,1, 2'd0,2'd2};
        vecs[3]  = '{itype(6'b000100,0,0),  1,0,5'd0, 0,0,5'd0, 0,5'd0, 0, 1,0,1, 2'd0,2'd0};
        vecs[4]  = '{itype(6'b000100,0,0),  1,1,5'd0, 0,0,5'd0, 0,5'd0, 1, 1,1,1, 2'd0,2'd0};
        vecs[5]  = '{itype(6'b000100,4,5),  1,0,5'd5, 0,0,5'd0, 0,5'd0, 1, 0,0,0, 2'd0,2'd0};
        vecs[6]  = '{itype(6'b000100,4,5),  0,0,5'd0, 1,1,5'd4, 0,5'd0, 1, 0,0,0, 2'd0,2'd0};
        vecs[7]  = '{itype(6'b000100,4,5),  0,0,5'd0, 1,0,5'd4, 1,5'd4, 0, 1,0,1, 2'd2,2'd0};
        vecs[8]  = '{itype(6'b000100,4,5),  0,0,5'd0, 0,0,5'd0, 1,5'd5, 1, 1,1,1, 2'd0,2'd3};
        vecs[9]  = '{{6'b000010,5'd8,21'h40}, 1,1,5'd8, 0,0,5'd0, 0,5'd0, 0, 1,0,0, 2'd0,2'd0};
        vecs[10] = '{itype(6'b101011,9,8),  1,1,5'd8, 0,0,5'd0, 0,5'd0, 0, 0,0,0, 2'd0,2'd0};
        vecs[11] = '{itype(6'b100011,8,10), 1,1,5'd10, 0,0,5'd0, 0,5'd0, 0, 1,0,0, 2'd0,2'd0};
        vecs[12] = '{rtype(2,8,1),          1,1,5'd8, 0,0,5'd0, 0,5'd0, 0, 0,0,0, 2'd0,2'd0};
        vecs[13] = '{rtype(8,8,1),          1,1,5'd8, 0,0,5'd0, 0,5'd0, 0, 0,0,0, 2'd0,2'd0};
        vecs[14] = '{rtype(8,2,9),          0,0,5'd0, 1,0,5'd8, 1,5'd2, 0, 1,0,0, 2'd0,2'd0};
        vecs[15] = '{itype(6'b000100,0,5),  0,0,5'd0, 1,0,5'd0, 1,5'd5, 0, 1,0,1, 2'd0,2'd3};
        vecs[16] = '{itype(6'b000101,6,7),  1,0,5'd9, 1,0,5'd6, 1,5'd7, 0, 1,0,1, 2'd2,2'd3};

        reset = 1'b1;
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk("rst state",      32'(ctlState),   32'd2);
        chk("rst pcWrite",    32'(pcWrite),    32'd0);
        chk("rst ifidWrite",  32'(ifidWrite),  32'd0);
        chk("rst bubble",     32'(idexBubble), 32'd1);
        chk("rst stallCount", 32'(stallCount), 32'd0);
        reset = 1'b0;
        #2;
        chk("post-rst state",   32'(ctlState), 32'd2);
        chk("post-rst pcWrite", 32'(pcWrite),  32'd0);
        @(posedge clk);
        #1;
        exp_cnt = 1;
        chk("run state",      32'(ctlState),   32'd0);
        chk("run pcWrite",    32'(pcWrite),    32'd1);
        chk("run stallCount", 32'(stallCount), 32'd1);

        for (int i = 0; i < NV; i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Load feeding a branch: two stalls, second in HOLD, then MEM/WB forward
        v = '{itype(6'b000100,4,5), 1,1,5'd4, 0,0,5'd0, 0,5'd0, 1, 0,0,0, 2'd0,2'd0};
        drive(v);
        #2;
        chk("ldbr s1 state",   32'(ctlState),      32'd0);
        chk("ldbr s1 pcWrite", 32'(pcWrite),       32'd0);
        chk("ldbr s1 resolve", 32'(branchResolve), 32'd0);
        chk("ldbr s1 flush",   32'(ifidFlush),     32'd0);
        @(posedge clk);
        #1;
        bump();
        v = '{itype(6'b000100,4,5), 0,0,5'd0, 1,1,5'd4, 0,5'd0, 1, 0,0,0, 2'd0,2'd0};
        drive(v);
        #2;
        chk("ldbr hold state",  32'(ctlState),   32'd1);
        chk("ldbr hold pcWrite", 32'(pcWrite),   32'd0);
        chk("ldbr hold bubble", 32'(idexBubble), 32'd1);
        chk("ldbr hold cnt",    32'(stallCount), 32'(exp_cnt));
        @(posedge clk);
        #1;
        bump();
        v = '{itype(6'b000100,4,5), 0,0,5'd0, 0,0,5'd0, 1,5'd4, 1, 1,1,1, 2'd3,2'd0};
        apply("ldbr resume", v);

        // Reset asserted while in HOLD
        v = '{itype(6'b000100,4,5), 1,1,5'd4, 0,0,5'd0, 0,5'd0, 0, 0,0,0, 2'd0,2'd0};
        drive(v);
        @(posedge clk);
        #1;
        bump();
        chk("rh hold state", 32'(ctlState), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rh async state",   32'(ctlState),   32'd2);
        chk("rh async pcWrite", 32'(pcWrite),    32'd0);
        chk("rh async bubble",  32'(idexBubble), 32'd1);
        chk("rh async cnt",     32'(stallCount), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(nop);
        #1;
        chk("rh rel state", 32'(ctlState), 32'd2);
        @(posedge clk);
        #1;
        exp_cnt = 1;
        apply("rh run0", nop);
        apply("rh run1", nop);

        // Hold a load-use hazard long enough to saturate the counter
        for (int i = 0; i < 20; i++)
            apply($sformatf("sat%0d", i), vecs[0]);
        #2;
        chk("sat final", 32'(stallCount), 32'((1 << CW) - 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
